// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug link: frame header, dump FSM states
// and field sizing helpers used by both the transmit and command-receive sides.
package debug_pkg;

  localparam logic [7:0] DBG_DUMP_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SNAP,
    ST_MADDR,
    ST_MBYTES,
    ST_CSUM,
    ST_DONE
  } dbg_state_e;

  function automatic int byte_len(input int width);
    return (width + 7) / 8;
  endfunction

  // PC + 32 registers + IF_ID/ID_EX/EX_MEM/MEM_WB at the default widths
  localparam int DBG_SNAP_BYTES = byte_len(32) + 32 * byte_len(32) + byte_len(64)
                                + byte_len(129) + byte_len(78) + byte_len(72);

endpackage

// File: rtl/debug_dump_tx_snapshot_shift_reg.sv
// Snapshot holding register: parallel load of the byte-padded snapshot,
// then shifted out one byte at a time, most significant byte first.
module snapshot_shift_reg #(
  parameter int BYTES = 176
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [BYTES*8-1:0] i_data,
  input  logic               i_shift,
  output logic [7:0]         o_top_byte
);

  logic [BYTES*8-1:0] shift_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q <= '0;
    end else if (i_load) begin
      shift_q <= i_data;
    end else if (i_shift) begin
      shift_q <= {shift_q[BYTES*8-9:0], 8'h00};
    end
  end

  assign o_top_byte = shift_q[BYTES*8-1 -: 8];

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump serializer: header, core snapshot, data memory and XOR checksum
// streamed byte by byte into the UART TX FIFO.
//
// state     | meaning
// ST_IDLE   | waiting for i_start
// ST_HDR    | offering the 0xA5 header byte
// ST_SNAP   | shifting out the PC/register/latch snapshot
// ST_MADDR  | memory address presented, read data arrives next cycle
// ST_MBYTES | sending the current memory word, MSB byte first
// ST_CSUM   | offering the checksum byte
// ST_DONE   | one-cycle completion pulse
module debug_dump_tx
  import debug_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int MEM_SIZE      = 64,
  parameter int ADDR_WIDTH    = $clog2(MEM_SIZE),
  parameter int IF_ID_SIZE    = 64,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 78,
  parameter int MEM_WB_SIZE   = 72
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [SIZE-1:0]               i_pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers_debug,
  input  logic [IF_ID_SIZE-1:0]         i_IF_ID,
  input  logic [ID_EX_SIZE-1:0]         i_ID_EX,
  input  logic [EX_MEM_SIZE-1:0]        i_EX_MEM,
  input  logic [MEM_WB_SIZE-1:0]        i_MEM_WB,
  output logic [ADDR_WIDTH-1:0]         o_debug_addr,
  input  logic [SIZE-1:0]               i_debug_data,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_full,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int WORD_B  = byte_len(SIZE);
  localparam int WORD_W  = WORD_B * 8;
  localparam int IFID_W  = byte_len(IF_ID_SIZE) * 8;
  localparam int IDEX_W  = byte_len(ID_EX_SIZE) * 8;
  localparam int EXMEM_W = byte_len(EX_MEM_SIZE) * 8;
  localparam int MEMWB_W = byte_len(MEM_WB_SIZE) * 8;
  localparam int SNAP_W  = WORD_W * (1 + NUM_REGISTERS) + IFID_W + IDEX_W + EXMEM_W + MEMWB_W;
  localparam int SNAP_B  = SNAP_W / 8;
  localparam int CNT_W   = $clog2(SNAP_B + 1);
  localparam int MB_W    = (WORD_B > 1) ? $clog2(WORD_B) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  dbg_state_e state_q, state_d;
  logic [CNT_W-1:0]      snap_cnt_q;
  logic [MB_W-1:0]       mbyte_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SIZE-1:0]       word_q;
  logic                  word_vld_q;
  logic [7:0]            csum_q;

  logic [NUM_REGISTERS*WORD_W-1:0] regs_pad;
  logic [SNAP_W-1:0]               snap_word;
  logic [WORD_W-1:0]               word_pad;
  logic [7:0]                      snap_byte;
  logic [7:0]                      tx_byte;
  logic                            snap_load;
  logic                            shift_en;
  logic                            tx_accept;

  // Register 0 sits at the LSBs of the input but goes out first on the wire
  always_comb begin
    regs_pad = '0;
    for (int k = 0; k < NUM_REGISTERS; k++) begin
      regs_pad[(NUM_REGISTERS-1-k)*WORD_W +: WORD_W] = WORD_W'(i_registers_debug[k*SIZE +: SIZE]);
    end
  end

  assign snap_word = {WORD_W'(i_pc), regs_pad, IFID_W'(i_IF_ID), IDEX_W'(i_ID_EX),
                      EXMEM_W'(i_EX_MEM), MEMWB_W'(i_MEM_WB)};

  snapshot_shift_reg #(
    .BYTES(SNAP_B)
  ) u_snap (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (snap_load),
    .i_data    (snap_word),
    .i_shift   (shift_en),
    .o_top_byte(snap_byte)
  );

  // Read data is only valid in the first MBYTES cycle; hold it for the rest of the word
  assign word_pad = WORD_W'(word_vld_q ? word_q : i_debug_data);

  assign o_tx_start = ((state_q == ST_HDR) || (state_q == ST_SNAP) ||
                       (state_q == ST_MBYTES) || (state_q == ST_CSUM)) && !i_tx_full;
  assign tx_accept    = o_tx_start;
  assign o_tx_data    = tx_byte;
  assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done       = (state_q == ST_DONE);
  assign o_debug_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    shift_en  = 1'b0;
    tx_byte   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_HDR;
          snap_load = 1'b1;
        end
      end
      ST_HDR: begin
        tx_byte = DBG_DUMP_HEADER;
        if (tx_accept) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        tx_byte  = snap_byte;
        shift_en = tx_accept;
        if (tx_accept && snap_cnt_q == '0) state_d = ST_MADDR;
      end
      ST_MADDR: state_d = ST_MBYTES;
      ST_MBYTES: begin
        tx_byte = word_pad[{mbyte_cnt_q, 3'b000} +: 8];
        if (tx_accept && mbyte_cnt_q == '0) state_d = (addr_q == LAST_ADDR) ? ST_CSUM : ST_MADDR;
      end
      ST_CSUM: begin
        tx_byte = csum_q;
        if (tx_accept) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      snap_cnt_q  <= '0;
      mbyte_cnt_q <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      csum_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            snap_cnt_q <= CNT_W'(SNAP_B - 1);
            addr_q     <= '0;
            csum_q     <= 8'h00;
          end
        end
        ST_SNAP: begin
          if (tx_accept) begin
            csum_q     <= csum_q ^ tx_byte;
            snap_cnt_q <= snap_cnt_q - 1'b1;
          end
        end
        ST_MADDR: begin
          word_vld_q  <= 1'b0;
          mbyte_cnt_q <= MB_W'(WORD_B - 1);
        end
        ST_MBYTES: begin
          if (!word_vld_q) begin
            word_q     <= i_debug_data;
            word_vld_q <= 1'b1;
          end
          if (tx_accept) begin
            csum_q      <= csum_q ^ tx_byte;
            mbyte_cnt_q <= mbyte_cnt_q - 1'b1;
            if (mbyte_cnt_q == '0 && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed-plus-random bench for debug_dump_tx: every accepted byte is
// captured and compared with a frame assembled from the inputs at start time.
module tb_debug_dump_tx;

  localparam int MODE_PLAIN    = 0;
  localparam int MODE_STALL    = 1;
  localparam int MODE_SCRAMBLE = 2;
  localparam int MODE_RESTART  = 3;
  localparam int MODE_RESET    = 4;
  localparam int FRAME_LEN     = 434;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  pc;
  logic [31:0]  regs [32];
  logic [1023:0] regs_flat;
  logic [63:0]  if_id;
  logic [128:0] id_ex;
  logic [77:0]  ex_mem;
  logic [71:0]  mem_wb;
  logic [5:0]   debug_addr;
  logic [31:0]  debug_data;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_full;
  logic         busy;
  logic         done;
  logic [31:0]  mem [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, done_cyc, viol;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  debug_dump_tx dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_pc             (pc),
    .i_registers_debug(regs_flat),
    .i_IF_ID          (if_id),
    .i_ID_EX          (id_ex),
    .i_EX_MEM         (ex_mem),
    .i_MEM_WB         (mem_wb),
    .o_debug_addr     (debug_addr),
    .i_debug_data     (debug_data),
    .o_tx_data        (tx_data),
    .o_tx_start       (tx_start),
    .i_tx_full        (tx_full),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < 32; k++) regs_flat[k*32 +: 32] = regs[k];
  end

  always @(posedge clk) debug_data <= mem[debug_addr];
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) cap_q.push_back(tx_data);
    if (tx_start && tx_full) viol++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_field(input logic [135:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  // Frame as the link defines it: header, fields MSB-first, XOR of all but header
  task automatic build_expected();
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    push_field(136'(pc), 4);
    for (int k = 0; k < 32; k++) push_field(136'(regs[k]), 4);
    push_field(136'(if_id), 8);
    push_field(136'(id_ex), 17);
    push_field(136'(ex_mem), 10);
    push_field(136'(mem_wb), 9);
    for (int w = 0; w < 64; w++) push_field(136'(mem[w]), 4);
    x = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
    exp_q.push_back(x);
  endtask

  task automatic randomize_core();
    logic [159:0] t;
    pc = $urandom;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if_id  = t[63:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    id_ex  = t[128:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ex_mem = t[77:0];
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mem_wb = t[71:0];
  endtask

  task automatic randomize_mem();
    for (int w = 0; w < 64; w++) mem[w] = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tx_start"}, 32'(tx_start), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
    check({tag, " debug_addr"}, 32'(debug_addr), 32'd0);
  endtask

  task automatic run_frame(input int mode, input string tag);
    int  start_cyc;
    int  exp_delta;
    int  bad;
    int  first_bad;
    bit  stalled;
    bit  restarted;
    bit  aborted;
    stalled   = 0;
    restarted = 0;
    aborted   = 0;
    exp_delta = 499;
    build_expected();
    cap_q.delete();
    done_cnt = 0;
    viol     = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (mode == MODE_SCRAMBLE) randomize_core();
      if (mode == MODE_STALL && !stalled && cap_q.size() == 15) begin
        tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_full = 1'b0;
        stalled   = 1;
        exp_delta = 504;
      end
      if (mode == MODE_RESTART && !restarted && cap_q.size() == 50) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        restarted = 1;
      end
      if (mode == MODE_RESET && cap_q.size() == 300) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs({tag, " after reset"});
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (aborted) begin
      repeat (5) @(posedge clk);
      check({tag, " no done after abort"}, 32'(done_cnt), 32'd0);
      return;
    end
    check({tag, " done seen"}, 32'(done_cnt != 0), 32'd1);
    check({tag, " frame length"}, 32'(cap_q.size()), 32'(FRAME_LEN));
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check({tag, " bytes differing"}, 32'(bad), 32'd0);
    if (first_bad >= 0)
      $display("  %s first differing byte index %0d", tag, first_bad);
    check({tag, " checksum"}, 32'(cap_q[FRAME_LEN-1]), 32'(exp_q[FRAME_LEN-1]));
    check({tag, " done latency"}, 32'(done_cyc - start_cyc), 32'(exp_delta));
    check({tag, " strobe while full"}, 32'(viol), 32'd0);
    @(negedge clk);
    check({tag, " busy after done"}, 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    check({tag, " single done"}, 32'(done_cnt), 32'd1);
    check({tag, " no extra bytes"}, 32'(cap_q.size()), 32'(FRAME_LEN));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    tx_full = 1'b0;
    pc      = '0;
    if_id   = '0;
    id_ex   = '0;
    ex_mem  = '0;
    mem_wb  = '0;
    for (int k = 0; k < 32; k++) regs[k] = '0;
    for (int w = 0; w < 64; w++) mem[w] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Start together with reset: reset must win
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start under reset busy", 32'(busy), 32'd0);
    check("start under reset tx_start", 32'(tx_start), 32'd0);

    // Directed frame with recognisable contents
    pc = 32'h0000_0010;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k);
    for (int w = 0; w < 64; w++) mem[w] = 32'hA000_0000 + 32'(w);
    run_frame(MODE_PLAIN, "directed");
    check("directed header", 32'(cap_q[0]), 32'hA5);
    check("directed pc lsb", 32'(cap_q[4]), 32'h10);
    check("directed reg31 lsb", 32'(cap_q[132]), 32'h1F);
    check("directed mem0 msb", 32'(cap_q[177]), 32'hA0);
    check("directed mem63 lsb", 32'(cap_q[432]), 32'h3F);

    // ID_EX padding: bit 128 lands in the LSB of the first ID_EX byte
    pc = '0;
    for (int k = 0; k < 32; k++) regs[k] = '0;
    id_ex = '0;
    id_ex[128] = 1'b1;
    randomize_mem();
    run_frame(MODE_PLAIN, "id_ex pad");
    begin
      int nz;
      nz = 0;
      for (int i = 142; i < 158; i++) if (cap_q[i] != 8'h00) nz++;
      check("id_ex first byte", 32'(cap_q[141]), 32'h01);
      check("id_ex trailing zeros", 32'(nz), 32'd0);
    end

    randomize_core();
    randomize_mem();
    run_frame(MODE_STALL, "stall");

    randomize_core();
    randomize_mem();
    run_frame(MODE_SCRAMBLE, "scramble");

    randomize_core();
    randomize_mem();
    run_frame(MODE_RESTART, "restart");

    randomize_core();
    randomize_mem();
    run_frame(MODE_RESET, "abort");

    randomize_core();
    randomize_mem();
    run_frame(MODE_PLAIN, "after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
